// File: rtl/pulse_qualifier.sv
// pulse_qualifier: multi-channel asynchronous event qualifier.
// Each channel synchronises one asynchronous line, waits for STABLE_CYCLES
// consecutive high samples, emits a one-cycle event, waits for the line to be
// released, and counts events in a saturating counter.
// Optional feature macro: PULSE_QUAL_TIMEOUT_EN adds a per-channel QUALIFY
// timeout of TIMEOUT_CYCLES cycles, reported on timeout_o.

// Two-flop synchroniser. SYNTHESIS != 0 selects the chain carrying placement
// attributes that keep both flops adjacent. The cycle behaviour is identical.
module sync_2dff #(
   parameter int unsigned SYNTHESIS = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   generate
      if (SYNTHESIS != 0) begin : gen_dyn
         (* ASYNC_REG = "TRUE" *) logic meta_q;
         (* ASYNC_REG = "TRUE" *) logic sync_q;

         // Two-stage capture of the asynchronous input
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               meta_q <= 1'b0;
               sync_q <= 1'b0;
            end else begin
               meta_q <= d_i;
               sync_q <= meta_q;
            end
         end

         assign q_o = sync_q;
      end else begin : gen_plain
         logic meta_q;
         logic sync_q;

         // Two-stage capture of the asynchronous input
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               meta_q <= 1'b0;
               sync_q <= 1'b0;
            end else begin
               meta_q <= d_i;
               sync_q <= meta_q;
            end
         end

         assign q_o = sync_q;
      end
   endgenerate

endmodule

module pulse_qualifier #(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned STABLE_CYCLES  = 2,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned DYNAMIC_CDC    = 1,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_CH-1:0]       async_pulse_i,
   input  logic                    en_i,
   input  logic                    clr_i,
   output logic [NUM_CH*CNT_W-1:0] count_o,
   output logic [NUM_CH-1:0]       event_o,
   output logic [NUM_CH-1:0]       sat_o,
   output logic [NUM_CH-1:0]       busy_o,
   output logic [NUM_CH-1:0]       timeout_o
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_QUALIFY = 3'd2,
      ST_DONE    = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

   // Run counter only has to hold 0 .. STABLE_CYCLES-1.
   localparam int unsigned      RUN_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_MAX - CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef PULSE_QUAL_TIMEOUT_EN
   localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
         logic             s;
         state_e           state_q;
         logic [RUN_W-1:0] run_q;
         logic [CNT_W-1:0] cnt_q;
         logic             sat_q;

         sync_2dff #(
            .SYNTHESIS (DYNAMIC_CDC)
         ) u_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (async_pulse_i[gi]),
            .q_o    (s)
         );

`ifdef PULSE_QUAL_TIMEOUT_EN
         logic [TMR_W-1:0] tmr_q;
         logic             timeout_q;

         // Channel FSM with QUALIFY timeout; qualification beats a same-cycle timeout
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               state_q   <= ST_IDLE;
               run_q     <= '0;
               tmr_q     <= '0;
               timeout_q <= 1'b0;
            end else begin
               timeout_q <= 1'b0;
               if (!en_i) begin
                  state_q <= ST_IDLE;
               end else begin
                  case (state_q)
                     ST_IDLE: begin
                        if (s) state_q <= ST_ARM;
                     end
                     ST_ARM: begin
                        run_q   <= '0;
                        tmr_q   <= '0;
                        state_q <= ST_QUALIFY;
                     end
                     ST_QUALIFY: begin
                        run_q <= s ? (run_q + RUN_ONE) : '0;
                        tmr_q <= tmr_q + TMR_ONE;
                        if (s && (run_q == RUN_LAST)) begin
                           state_q <= ST_DONE;
                        end else if (tmr_q == TMR_LAST) begin
                           state_q   <= ST_IDLE;
                           timeout_q <= 1'b1;
                        end
                     end
                     ST_DONE: begin
                        state_q <= ST_RELEASE;
                     end
                     ST_RELEASE: begin
                        if (!s) state_q <= ST_IDLE;
                     end
                     default: begin
                        state_q <= ST_IDLE;
                     end
                  endcase
               end
            end
         end

         assign timeout_o[gi] = timeout_q;
`else
         // Channel FSM: arm, qualify a run of high samples, fire, wait for release
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               state_q <= ST_IDLE;
               run_q   <= '0;
            end else begin
               if (!en_i) begin
                  state_q <= ST_IDLE;
               end else begin
                  case (state_q)
                     ST_IDLE: begin
                        if (s) state_q <= ST_ARM;
                     end
                     ST_ARM: begin
                        run_q   <= '0;
                        state_q <= ST_QUALIFY;
                     end
                     ST_QUALIFY: begin
                        run_q <= s ? (run_q + RUN_ONE) : '0;
                        if (s && (run_q == RUN_LAST)) state_q <= ST_DONE;
                     end
                     ST_DONE: begin
                        state_q <= ST_RELEASE;
                     end
                     ST_RELEASE: begin
                        if (!s) state_q <= ST_IDLE;
                     end
                     default: begin
                        state_q <= ST_IDLE;
                     end
                  endcase
               end
            end
         end

         assign timeout_o[gi] = 1'b0;
`endif

         // Saturating event counter; clear wins over a same-cycle increment
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               cnt_q <= '0;
               sat_q <= 1'b0;
            end else if (clr_i) begin
               cnt_q <= '0;
               sat_q <= 1'b0;
            end else if ((state_q == ST_DONE) && (cnt_q != CNT_MAX)) begin
               cnt_q <= cnt_q + CNT_ONE;
               if (cnt_q == CNT_PRE) sat_q <= 1'b1;
            end
         end

         // Outputs decode registered state only, so no input-to-output path exists
         assign count_o[gi*CNT_W +: CNT_W] = cnt_q;
         assign event_o[gi]                = (state_q == ST_DONE);
         assign busy_o[gi]                 = (state_q != ST_IDLE);
         assign sat_o[gi]                  = sat_q;
      end
   endgenerate

endmodule

// File: tb/tb_pulse_qualifier.sv
// Bench for pulse_qualifier: a behavioural channel model checked every cycle
// against two instances (dynamic and plain synchroniser), plus directed
// scenarios with hand-computed expectations.
module tb_pulse_qualifier;

   localparam int NCH  = 4;
   localparam int STB  = 2;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic [NCH-1:0]  async_pulse;
   logic            en;
   logic            clr;

   logic [NCH*CW-1:0] count, count0;
   logic [NCH-1:0]    event_w, sat, busy, tmo;
   logic [NCH-1:0]    event0, sat0, busy0, tmo0;

   int total;
   int bad;

   always #5 clk = ~clk;

   pulse_qualifier #(
      .NUM_CH(NCH), .STABLE_CYCLES(STB), .CNT_W(CW), .DYNAMIC_CDC(1), .TIMEOUT_CYCLES(8)
   ) u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .async_pulse_i(async_pulse), .en_i(en), .clr_i(clr),
      .count_o(count), .event_o(event_w), .sat_o(sat), .busy_o(busy), .timeout_o(tmo)
   );

   pulse_qualifier #(
      .NUM_CH(NCH), .STABLE_CYCLES(STB), .CNT_W(CW), .DYNAMIC_CDC(0), .TIMEOUT_CYCLES(8)
   ) u_dut0 (
      .clk_i(clk), .rst_ni(rst_ni), .async_pulse_i(async_pulse), .en_i(en), .clr_i(clr),
      .count_o(count0), .event_o(event0), .sat_o(sat0), .busy_o(busy0), .timeout_o(tmo0)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Per channel: a two-sample delay line for the synchroniser, then
   // "busy / arming / window(need N more highs) / fired / waiting for low".
   bit m_s1  [NCH];
   bit m_s2  [NCH];
   bit m_busy[NCH];
   bit m_arm [NCH];
   bit m_win [NCH];
   bit m_fire[NCH];
   bit m_wait[NCH];
   int m_need[NCH];
   int m_cnt [NCH];
   bit m_sat [NCH];

   initial begin
      logic [NCH*CW-1:0] ec;
      logic [NCH-1:0]    ee, es, eb;
      bit                sv;
      forever begin
         @(posedge clk);
         for (int k = 0; k < NCH; k++) begin
            if (!rst_ni) begin
               m_s1[k] = 0; m_s2[k] = 0; m_busy[k] = 0; m_arm[k] = 0; m_win[k] = 0;
               m_fire[k] = 0; m_wait[k] = 0; m_need[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
            end else begin
               sv = m_s2[k];
               if (clr) begin
                  m_cnt[k] = 0;
                  m_sat[k] = 0;
               end else if (m_fire[k] && m_cnt[k] < CMAX) begin
                  m_cnt[k]++;
                  if (m_cnt[k] == CMAX) m_sat[k] = 1;
               end
               if (!en) begin
                  m_busy[k] = 0; m_arm[k] = 0; m_win[k] = 0; m_fire[k] = 0; m_wait[k] = 0;
               end else if (!m_busy[k]) begin
                  if (sv) begin m_busy[k] = 1; m_arm[k] = 1; end
               end else if (m_arm[k]) begin
                  m_arm[k] = 0; m_win[k] = 1; m_need[k] = STB;
               end else if (m_win[k]) begin
                  if (sv) begin
                     m_need[k]--;
                     if (m_need[k] == 0) begin m_win[k] = 0; m_fire[k] = 1; end
                  end else begin
                     m_need[k] = STB;
                  end
               end else if (m_fire[k]) begin
                  m_fire[k] = 0; m_wait[k] = 1;
               end else if (m_wait[k]) begin
                  if (!sv) begin m_wait[k] = 0; m_busy[k] = 0; end
               end
               m_s2[k] = m_s1[k];
               m_s1[k] = async_pulse[k];
            end
         end
         #1;
         for (int k = 0; k < NCH; k++) begin
            ec[k*CW +: CW] = CW'(m_cnt[k]);
            ee[k] = m_fire[k];
            es[k] = m_sat[k];
            eb[k] = m_busy[k];
         end
         chk("count_o", count, ec);
         chk("event_o", event_w, ee);
         chk("sat_o", sat, es);
         chk("busy_o", busy, eb);
         chk("timeout_o", tmo, '0);
         chk("plain_cdc_outputs", {count0, event0, sat0, busy0, tmo0}, {ec, ee, es, eb, 4'b0000});
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int ev_n, ev_cnt, seen, viol, evs, found;
      int hold[NCH];
      total = 0; bad = 0;
      rst_ni = 1'b0; async_pulse = '0; en = 1'b1; clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_count", count, 0);
      chk("reset_busy", busy, 0);
      chk("reset_event", event_w, 0);
      chk("reset_sat", sat, 0);
      chk("reset_timeout", tmo, 0);
      $display("reset released");
      rst_ni = 1'b1;

      // ch0 held high for 20 cycles: single event, 6 samples after the drive
      @(negedge clk);
      async_pulse[0] = 1'b1;
      ev_n = 0; ev_cnt = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (event_w[0]) begin
            ev_cnt++;
            if (ev_n == 0) ev_n = n;
         end
      end
      chk("ch0_event_latency", ev_n, 6);
      chk("ch0_event_count", ev_cnt, 1);
      chk("ch0_count", count[1:0], 1);
      chk("ch1to3_count", count[7:2], 0);
      chk("model_pin_cnt0", m_cnt[0], 1);
      $display("ch0 held high: event at sample %0d, count0=%0d", ev_n, count[1:0]);
      @(negedge clk);
      async_pulse[0] = 1'b0;
      repeat (5) @(negedge clk);

      // clr_i coinciding with ch0 DONE: the event is lost
      async_pulse[0] = 1'b1;
      found = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (event_w[0]) begin found = 1; break; end
      end
      chk("clr_done_seen", found, 1);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      async_pulse[0] = 1'b0;
      chk("clr_done_count0", count[1:0], 0);
      chk("clr_done_sat0", sat[0], 0);
      $display("clear at DONE: count0=%0d", count[1:0]);
      repeat (6) @(negedge clk);

      // ch1 toggling every cycle never qualifies
      seen = 0; viol = 0; evs = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         async_pulse[1] = (i % 2 == 0);
         @(posedge clk); #1;
         if (busy[1]) seen = 1;
         else if (seen != 0) viol++;
         if (event_w[1]) evs++;
      end
      chk("ch1_toggle_busy_seen", seen, 1);
      chk("ch1_toggle_busy_drop", viol, 0);
      chk("ch1_toggle_events", evs, 0);
      chk("ch1_toggle_count", count[3:2], 0);
      @(negedge clk);
      async_pulse[1] = 1'b0;
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      chk("ch1_en_abort_busy", busy[1], 0);
      $display("ch1 toggling: busy_seen=%0d drops=%0d events=%0d", seen, viol, evs);
      repeat (4) @(negedge clk);

      // ch2 pulsed eight times with a 2-bit counter: saturates at 3
      for (int p = 1; p <= 8; p++) begin
         async_pulse[2] = 1'b1;
         repeat (6) @(negedge clk);
         async_pulse[2] = 1'b0;
         repeat (4) @(negedge clk);
         chk("ch2_sat_count", count[5:4], (p < 3) ? p : 3);
         chk("ch2_sat_flag", sat[2], (p >= 3) ? 1 : 0);
         $display("ch2 pulse %0d: count2=%0d sat2=%0d", p, count[5:4], sat[2]);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("ch2_clr_count", count[5:4], 0);
      chk("ch2_clr_sat", sat[2], 0);
      repeat (3) @(negedge clk);

      // en_i dropped while ch3 is in QUALIFY
      async_pulse[3] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("ch3_qualify_busy", busy[3], 1);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk); #1;
      chk("ch3_abort_busy", busy[3], 0);
      evs = 0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         if (event_w[3]) evs++;
      end
      chk("ch3_abort_events", evs, 0);
      @(negedge clk);
      async_pulse[3] = 1'b0;
      repeat (4) @(negedge clk);
      en = 1'b1;
      repeat (3) @(negedge clk);
      chk("ch3_abort_count", count[7:6], 0);
      $display("ch3 en abort: busy3=%0d count3=%0d", busy[3], count[7:6]);

      // random asynchronous streams on all channels
      for (int k = 0; k < NCH; k++) hold[k] = 0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         for (int k = 0; k < NCH; k++) begin
            if (hold[k] == 0) begin
               async_pulse[k] = ~async_pulse[k];
               hold[k] = $urandom_range(1, 8);
            end else begin
               hold[k]--;
            end
         end
         en  = ($urandom_range(0, 199) != 0);
         clr = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      en = 1'b1; clr = 1'b0; async_pulse = '0;
      $display("random phase done: counts=%0h sat=%0h", count, sat);
      repeat (6) @(negedge clk);

      // reset in the middle of ch0 qualification
      async_pulse[0] = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_count", count, 0);
      chk("midrst_event", event_w, 0);
      chk("midrst_sat", sat, 0);
      @(negedge clk);
      async_pulse = '0;
      @(negedge clk);
      rst_ni = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_count", count, 0);
      $display("mid-operation reset: busy=%0h count=%0h", busy, count);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
